pw_seq_lock: RTL

PW_SEQ_LOCK -- requirements
Module: pw_seq_lock

---
 rtl/pw_seq_lock.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/pw_seq_lock.sv
// pw_seq_lock: sequential password lock with retry lockout.
// Optional build macro: PW_FAULT_DETECT_EN (dual comparator + alarm).
//
// Ports:
//   clk        - single clock, rising edge
//   reset_n    - asynchronous active-low reset
//   char_in    - character sampled on each enter press
//   enter      - debounced, clk-synchronous button level
//   open       - lock open (registered)
//   wrong      - last attempt wrong (registered)
//   locked_out - lockout window active (registered)
//   alarm      - sticky fault flag (0 unless PW_FAULT_DETECT_EN)
module pw_seq_lock #(
   parameter int PW_LEN = 4,
   parameter int CHAR_W = 8,
   parameter logic [PW_LEN*CHAR_W-1:0] PASSWORD = 32'h31323334,
   parameter int MAX_TRIES = 3,
   parameter int LOCKOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [CHAR_W-1:0] char_in,
   input  logic              enter,
   output logic              open,
   output logic              wrong,
   output logic              locked_out,
   output logic              alarm
);

   localparam int PW_W  = PW_LEN * CHAR_W;
   localparam int IDX_W = $clog2(PW_LEN + 1);
   localparam int TMR_W = $clog2(LOCKOUT_CYCLES + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PW_LEN - 1);
   localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(LOCKOUT_CYCLES - 1);
   localparam logic [7:0]       FAIL_MAX = 8'(MAX_TRIES);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_CHECK   = 3'd2,
      S_OPEN    = 3'd3,
      S_WRONG   = 3'd4,
      S_LOCKOUT = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic              enter_q, enter_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [7:0]        fail_q, fail_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [CHAR_W-1:0] chars_q [PW_LEN];
   logic [CHAR_W-1:0] chars_d [PW_LEN];
   logic              open_q, open_d;
   logic              wrong_q, wrong_d;
   logic              lock_q, lock_d;

   logic              press;
   logic [PW_W-1:0]   pw_vec;
   logic              match_t;
   logic [7:0]        fail_inc;
   logic              chk_fault;

   assign press    = enter & ~enter_q;
   assign fail_inc = fail_q + 8'd1;

   // Slot 0 is the first character and lines up with the MS bits.
   always_comb begin
      pw_vec = '0;
      for (int i = 0; i < PW_LEN; i++) begin
         pw_vec[(PW_LEN-1-i)*CHAR_W +: CHAR_W] = chars_q[i];
      end
   end

   assign match_t = (pw_vec == PASSWORD);

`ifdef PW_FAULT_DETECT_EN
   logic alarm_q, alarm_d;
   logic cmp_inv;
   logic bad_state;

   // Independent inverted-polarity compare: 1 means mismatch.
   assign cmp_inv   = ~(&(pw_vec ~^ PASSWORD));
   // Healthy comparators always disagree in polarity.
   assign chk_fault = (match_t == cmp_inv) | alarm_q;
   assign bad_state = !(state_q inside {S_IDLE, S_ENTRY, S_CHECK,
                                        S_OPEN, S_WRONG, S_LOCKOUT});

   always_comb begin
      alarm_d = alarm_q | bad_state |
                ((state_q == S_CHECK) & chk_fault);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alarm_q <= 1'b0;
      end else begin
         alarm_q <= alarm_d;
      end
   end

   assign alarm = alarm_q;
`else
   assign chk_fault = 1'b0;
   assign alarm     = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      enter_d = enter;
      idx_d   = idx_q;
      fail_d  = fail_q;
      tmr_d   = tmr_q;
      chars_d = chars_q;

      unique case (state_q)
         S_IDLE, S_OPEN, S_WRONG: begin
            if (press) begin
               chars_d[0] = char_in;
               idx_d      = IDX_W'(1);
               state_d    = (PW_LEN == 1) ? S_CHECK : S_ENTRY;
            end
         end

         S_ENTRY: begin
            if (press) begin
               for (int i = 0; i < PW_LEN; i++) begin
                  if (idx_q == IDX_W'(i)) begin
                     chars_d[i] = char_in;
                  end
               end
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) begin
                  state_d = S_CHECK;
               end
            end
         end

         S_CHECK: begin
            idx_d = '0;
            if (chk_fault) begin
               state_d = S_LOCKOUT;
               tmr_d   = '0;
            end else if (match_t) begin
               state_d = S_OPEN;
               fail_d  = '0;
            end else if (fail_inc >= FAIL_MAX) begin
               state_d = S_LOCKOUT;
               fail_d  = fail_inc;
               tmr_d   = '0;
            end else begin
               state_d = S_WRONG;
               fail_d  = fail_inc;
            end
         end

         S_LOCKOUT: begin
            idx_d = '0;
            if (tmr_q == TMR_END) begin
               state_d = S_IDLE;
               fail_d  = '0;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         default: begin
            idx_d = '0;
            tmr_d = '0;
`ifdef PW_FAULT_DETECT_EN
            state_d = S_LOCKOUT;
`else
            state_d = S_IDLE;
`endif
         end
      endcase
   end

   // Outputs follow the registered state one edge later, so the
   // flags are glitch-free flops and mutually exclusive.
   always_comb begin
      open_d  = (state_q == S_OPEN);
      wrong_d = (state_q == S_WRONG);
      lock_d  = (state_q == S_LOCKOUT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         enter_q <= 1'b0;
         idx_q   <= '0;
         fail_q  <= '0;
         tmr_q   <= '0;
         open_q  <= 1'b0;
         wrong_q <= 1'b0;
         lock_q  <= 1'b0;
         for (int i = 0; i < PW_LEN; i++) begin
            chars_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         enter_q <= enter_d;
         idx_q   <= idx_d;
         fail_q  <= fail_d;
         tmr_q   <= tmr_d;
         open_q  <= open_d;
         wrong_q <= wrong_d;
         lock_q  <= lock_d;
         for (int i = 0; i < PW_LEN; i++) begin
            chars_q[i] <= chars_d[i];
         end
      end
   end

   assign open       = open_q;
   assign wrong      = wrong_q;
   assign locked_out = lock_q;

endmodule
